reg_file_demux: RTL and testbench
=================================

Name: reg_file_demux

Overview:
- Write-side counterpart of the datapath bus select: takes the single 16-bit shared bus and distributes it into one of 8 general registers.
- Dest-select demux drives per-register load enables; the register array drives two read ports (SR1, SR2).
- Also holds the NZP condition-code register, updated from the bus value.
- Sits between the bus gate logic and the ALU/address adders in the SLC-3 datapath.

Parameters:
- WIDTH, 16, data word width of bus and registers
- NREGS, 8, number of general registers; power of two
- SEL_W, 3, select width; equals log2(NREGS)

Ports:
- Clk  input  1  system clock; all state updates on rising edge
- Reset_n  input  1  synchronous, active-low reset
- Bus  input  WIDTH  shared datapath bus value
- DR  input  SEL_W  destination register select
- LD_REG  input  1  write enable for register DR
- LD_CC  input  1  load NZP from Bus
- SR1  input  SEL_W  read port 1 select
- SR2  input  SEL_W  read port 2 select
- SR1_out  output  WIDTH  contents of register SR1
- SR2_out  output  WIDTH  contents of register SR2
- NZP  output  3  condition codes {N,Z,P}
- Dest_onehot  output  NREGS  registered one-hot image of the last accepted write; bit i = register i written last cycle

Behaviour:
- Reset: on a rising edge with Reset_n=0, all registers clear to 0, NZP clears to 3'b010, Dest_onehot clears to 0.
- Reset priority: reset overrides LD_REG and LD_CC in the same cycle. A reset asserted mid-sequence discards the pending write.
- Write: on a rising edge with Reset_n=1 and LD_REG=1, register[DR] <= Bus. Latency is 1 cycle. All other registers hold.
- LD_REG=0: no register changes.
- Decoder: the write decoder produces one-hot en[i] = LD_REG & (DR==i). At most one bit is ever set.
- Dest_onehot: registered copy of en, updated every cycle. It returns to 0 on the cycle after a cycle with no write.
- Condition codes: on a rising edge with LD_CC=1:
  - N = Bus[WIDTH-1]
  - Z = (Bus == 0)
  - P = ~N & ~Z
  - Exactly one NZP bit is set after any load.
- LD_CC and LD_REG are independent. Both asserted in the same cycle update both from the same Bus value.
- Read ports: SR1_out and SR2_out are combinational reads of the register array and show pre-edge contents.
  - SR1 == SR2 is legal; both ports show the same value.
  - Reading DR in the cycle it is being written returns the old value unless WRITE_BYPASS_EN is defined.
- Boundaries:
  - DR = NREGS-1 (R7) is writable like any other register; no special cases.
  - Bus = 16'h8000 yields N=1.
  - Bus = 16'h7FFF yields P=1.
  - Back-to-back writes to the same DR on consecutive cycles: the last one wins.
- No X propagation: all selects are full-range, so every select value is legal.

Optional Feature:
- Macro: REG_FILE_WRITE_BYPASS_EN.
- Defined: if LD_REG=1 and SRx==DR, SRx_out = Bus in the same cycle (write-through forwarding). This applies per port independently.
- Undefined: read ports always return stored contents; the new value is visible the cycle after the write.
- Neither setting changes NZP or Dest_onehot behaviour.

Decomposition:
- Shared package slc3_pkg:
  - typedef word_t (logic [15:0])
  - typedef reg_sel_t (logic [2:0])
  - typedef nzp_t (logic [2:0])
  - constant NZP_RESET = 3'b010
  - function calc_nzp(word_t)
- One sub-module: dest_decoder, a combinational SEL_W-to-NREGS one-hot decoder gated by an enable. It is the write-side mirror of the bus mux.
- The register array and the NZP register stay in reg_file_demux.

Test Plan:
- Reset: hold Reset_n=0 for 2 cycles with LD_REG=1, Bus=16'hFFFF → all registers read 0, NZP=3'b010, Dest_onehot=0.
- Fill: write R0..R7 with 16'h1000+i via DR=i, LD_REG=1 → sweeping SR1 and SR2 over 0..7 returns 16'h1000+i; Dest_onehot shows 8'b1<<i one cycle after each write.
- NZP: LD_CC with Bus = 16'h8000, then 16'h0000, then 16'h0001 → NZP = 100, then 010, then 001. With LD_CC=0 and Bus=16'h8000, NZP holds at 001.
- Same-cycle read of the written register: R3=16'hAAAA; write DR=3, Bus=16'h5555 with SR1=SR2=3:
  - Without bypass: 16'hAAAA during the write cycle, 16'h5555 after.
  - With REG_FILE_WRITE_BYPASS_EN: 16'h5555 in the same cycle.
- Simultaneous loads: LD_REG=1, LD_CC=1, DR=7, Bus=16'hFFFE → R7=16'hFFFE, NZP=100, no other register changed.
- Reset mid-operation: Reset_n=0 in the same cycle as a write of 16'h1234 to R2 → R2=0 and NZP=010 after the edge. A subsequent write with Reset_n=1 succeeds.

Source files
------------

// File: rtl/slc3_pkg.sv
// Shared SLC-3 datapath types and the condition-code helper used by the register file.
package slc3_pkg;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  reg_sel_t;
  typedef logic [2:0]  nzp_t;

  localparam nzp_t NZP_RESET = 3'b010;

  // Returns {N,Z,P}; exactly one bit is always set.
  function automatic nzp_t calc_nzp(input word_t value);
    logic n;
    logic z;
    n = value[15];
    z = (value == '0);
    return {n, z, ~n & ~z};
  endfunction

endpackage

// File: rtl/dest_decoder.sv
// Enable-gated SEL_W-to-NREGS one-hot decoder; write-side mirror of the bus mux.
module dest_decoder #(
  parameter int NREGS = 8,
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             enable,
  output logic [NREGS-1:0] onehot
);

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_dec
    assign onehot[gi] = enable && (sel == SEL_W'(gi));
  end

endmodule

// File: rtl/reg_file_demux.sv
// General register file with one write port, two combinational read ports and NZP.
// Optional macro REG_FILE_WRITE_BYPASS_EN forwards Bus to a read port addressing DR during a write.
module reg_file_demux
  import slc3_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int SEL_W = 3
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Bus,
  input  logic [SEL_W-1:0] DR,
  input  logic             LD_REG,
  input  logic             LD_CC,
  input  logic [SEL_W-1:0] SR1,
  input  logic [SEL_W-1:0] SR2,
  output logic [WIDTH-1:0] SR1_out,
  output logic [WIDTH-1:0] SR2_out,
  output logic [2:0]       NZP,
  output logic [NREGS-1:0] Dest_onehot
);

  logic [WIDTH-1:0] regs_reg [NREGS];
  logic [NREGS-1:0] en;
  nzp_t             nzp_reg;
  logic [NREGS-1:0] dest_reg;

  dest_decoder #(
    .NREGS (NREGS),
    .SEL_W (SEL_W)
  ) u_dest_decoder (
    .sel    (DR),
    .enable (LD_REG),
    .onehot (en)
  );

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
    always_ff @(posedge Clk) begin
      if (!Reset_n) begin
        regs_reg[gi] <= '0;
      end else if (en[gi]) begin
        regs_reg[gi] <= Bus;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      nzp_reg  <= NZP_RESET;
      dest_reg <= '0;
    end else begin
      if (LD_CC) begin
        nzp_reg <= calc_nzp(word_t'(Bus));
      end
      dest_reg <= en;
    end
  end

`ifdef REG_FILE_WRITE_BYPASS_EN
  assign SR1_out = (LD_REG && (SR1 == DR)) ? Bus : regs_reg[SR1];
  assign SR2_out = (LD_REG && (SR2 == DR)) ? Bus : regs_reg[SR2];
`else
  assign SR1_out = regs_reg[SR1];
  assign SR2_out = regs_reg[SR2];
`endif

  assign NZP         = nzp_reg;
  assign Dest_onehot = dest_reg;

endmodule

// File: tb/tb_reg_file_demux.sv
// Directed bench for reg_file_demux; build with REG_FILE_WRITE_BYPASS_EN to check forwarding.
module tb_reg_file_demux;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [15:0] Bus;
  logic [2:0]  DR;
  logic        LD_REG;
  logic        LD_CC;
  logic [2:0]  SR1;
  logic [2:0]  SR2;
  logic [15:0] SR1_out;
  logic [15:0] SR2_out;
  logic [2:0]  NZP;
  logic [7:0]  Dest_onehot;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 Clk = ~Clk;

  reg_file_demux dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Bus         (Bus),
    .DR          (DR),
    .LD_REG      (LD_REG),
    .LD_CC       (LD_CC),
    .SR1         (SR1),
    .SR2         (SR2),
    .SR1_out     (SR1_out),
    .SR2_out     (SR2_out),
    .NZP         (NZP),
    .Dest_onehot (Dest_onehot)
  );

  // One clock edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    $display("[TB] t=%0t rst_n=%b ld_reg=%b ld_cc=%b dr=%0d bus=%h", $time, Reset_n, LD_REG, LD_CC, DR, Bus);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; LD_REG = 1'b1; LD_CC = 1'b1; Bus = 16'hFFFF; DR = 3'd5;
    tick();
    tick();
    LD_REG = 1'b0; LD_CC = 1'b0;
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i); SR2 = 3'(7 - i);
      #1;
      tests_run++;
      if (SR1_out !== 16'h0000 || SR2_out !== 16'h0000) begin
        tests_failed++;
        $display("FAIL reset_regs i=%0d got sr1=%h sr2=%h expected 0000", i, SR1_out, SR2_out);
      end
    end
    tests_run++;
    if (NZP !== 3'b010) begin
      tests_failed++;
      $display("FAIL reset_nzp got %b expected 010", NZP);
    end
    tests_run++;
    if (Dest_onehot !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_dest got %b expected 00000000", Dest_onehot);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      DR = 3'(i); Bus = 16'h1000 + 16'(i); LD_REG = 1'b1;
      tick();
      tests_run++;
      if (Dest_onehot !== (8'h01 << i)) begin
        tests_failed++;
        $display("FAIL fill_dest i=%0d got %b expected %b", i, Dest_onehot, 8'h01 << i);
      end
    end
    LD_REG = 1'b0;
    tick();
    tests_run++;
    if (Dest_onehot !== 8'h00) begin
      tests_failed++;
      $display("FAIL fill_dest_idle got %b expected 00000000", Dest_onehot);
    end
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i); SR2 = 3'(7 - i);
      #1;
      tests_run++;
      if (SR1_out !== 16'h1000 + 16'(i) || SR2_out !== 16'h1000 + 16'(7 - i)) begin
        tests_failed++;
        $display("FAIL fill_read i=%0d got sr1=%h sr2=%h expected %h %h",
                 i, SR1_out, SR2_out, 16'h1000 + 16'(i), 16'h1000 + 16'(7 - i));
      end
    end
  endtask

  task automatic test_nzp();
    logic [15:0] vals [4];
    logic [2:0]  exps [4];
    vals = '{16'h8000, 16'h0000, 16'h7FFF, 16'h0001};
    exps = '{3'b100, 3'b010, 3'b001, 3'b001};
    LD_REG = 1'b0;
    for (int i = 0; i < 4; i++) begin
      LD_CC = 1'b1; Bus = vals[i];
      tick();
      tests_run++;
      if (NZP !== exps[i]) begin
        tests_failed++;
        $display("FAIL nzp_load bus=%h got %b expected %b", vals[i], NZP, exps[i]);
      end
    end
    LD_CC = 1'b0; Bus = 16'h8000;
    tick();
    tests_run++;
    if (NZP !== 3'b001) begin
      tests_failed++;
      $display("FAIL nzp_hold got %b expected 001", NZP);
    end
  endtask

  task automatic test_same_cycle_read();
    logic [15:0] during;
`ifdef REG_FILE_WRITE_BYPASS_EN
    during = 16'h5555;
`else
    during = 16'hAAAA;
`endif
    DR = 3'd3; Bus = 16'hAAAA; LD_REG = 1'b1; LD_CC = 1'b0;
    tick();
    Bus = 16'h5555; SR1 = 3'd3; SR2 = 3'd3;
    #1;
    tests_run++;
    if (SR1_out !== during || SR2_out !== during) begin
      tests_failed++;
      $display("FAIL same_cycle_during got sr1=%h sr2=%h expected %h", SR1_out, SR2_out, during);
    end
    tick();
    LD_REG = 1'b0;
    #1;
    tests_run++;
    if (SR1_out !== 16'h5555 || SR2_out !== 16'h5555) begin
      tests_failed++;
      $display("FAIL same_cycle_after got sr1=%h sr2=%h expected 5555", SR1_out, SR2_out);
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp_regs [8];
    exp_regs = '{16'h1000, 16'h1001, 16'h1002, 16'h5555, 16'h1004, 16'h1005, 16'h1006, 16'hFFFE};
    DR = 3'd7; Bus = 16'hFFFE; LD_REG = 1'b1; LD_CC = 1'b1;
    tick();
    LD_REG = 1'b0; LD_CC = 1'b0;
    tests_run++;
    if (NZP !== 3'b100) begin
      tests_failed++;
      $display("FAIL simul_nzp got %b expected 100", NZP);
    end
    tests_run++;
    if (Dest_onehot !== 8'h80) begin
      tests_failed++;
      $display("FAIL simul_dest got %b expected 10000000", Dest_onehot);
    end
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i); SR2 = 3'(i);
      #1;
      tests_run++;
      if (SR1_out !== exp_regs[i] || SR2_out !== exp_regs[i]) begin
        tests_failed++;
        $display("FAIL simul_regs i=%0d got sr1=%h sr2=%h expected %h", i, SR1_out, SR2_out, exp_regs[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    DR = 3'd1; LD_REG = 1'b1; Bus = 16'h1111;
    tick();
    Bus = 16'h2222;
    tick();
    LD_REG = 1'b0; SR1 = 3'd1; SR2 = 3'd0;
    #1;
    tests_run++;
    if (SR1_out !== 16'h2222 || SR2_out !== 16'h1000) begin
      tests_failed++;
      $display("FAIL back_to_back got r1=%h r0=%h expected 2222 1000", SR1_out, SR2_out);
    end
    tests_run++;
    if (Dest_onehot !== 8'h02) begin
      tests_failed++;
      $display("FAIL back_to_back_dest got %b expected 00000010", Dest_onehot);
    end
  endtask

  task automatic test_reset_mid();
    DR = 3'd2; Bus = 16'h1234; LD_REG = 1'b1; LD_CC = 1'b1; Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1; LD_REG = 1'b0; LD_CC = 1'b0; SR1 = 3'd2; SR2 = 3'd7;
    #1;
    tests_run++;
    if (SR1_out !== 16'h0000 || SR2_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_mid_regs got r2=%h r7=%h expected 0000", SR1_out, SR2_out);
    end
    tests_run++;
    if (NZP !== 3'b010 || Dest_onehot !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_state got nzp=%b dest=%b expected 010 00000000", NZP, Dest_onehot);
    end
    LD_REG = 1'b1; Bus = 16'h1234;
    tick();
    LD_REG = 1'b0;
    #1;
    tests_run++;
    if (SR1_out !== 16'h1234 || Dest_onehot !== 8'h04) begin
      tests_failed++;
      $display("FAIL reset_mid_rewrite got r2=%h dest=%b expected 1234 00000100", SR1_out, Dest_onehot);
    end
  endtask

  initial begin
    Reset_n = 1'b0; Bus = '0; DR = '0; LD_REG = 1'b0; LD_CC = 1'b0; SR1 = '0; SR2 = '0;
    test_reset();
    test_fill();
    test_nzp();
    test_same_cycle_read();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
